// File: rtl/prbs26_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs26_checker
// Description : Self-synchronising checker for the 26-bit PRBS generator
//               stream (y(n) = y(n-19)^y(n-20)^y(n-25)^y(n-26)).
// Revision    : 1.0 - initial release
// ============================================================================
module prbs26_checker #(
    parameter int LOCK_CNT = 64,
    parameter int WIN_LEN  = 256,
    parameter int LOSS_ERR = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             din,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [31:0]      bit_cnt
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]  c_LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [15:0] c_WIN_LAST  = 16'(WIN_LEN - 1);
    localparam logic [15:0] c_LOSS_ERR  = 16'(LOSS_ERR);

    state_t             r_state, w_state_nx;
    logic [25:0]        r_hist, w_hist_nx;     // r_hist[k-1] is h[k]
    logic [4:0]         r_fill, w_fill_nx;
    logic [7:0]         r_match, w_match_nx;
    logic [15:0]        r_win_bits, w_win_bits_nx;
    logic [15:0]        r_win_err, w_win_err_nx;
    logic               r_locked;
    logic               r_err_pulse;
    logic [CNT_W-1:0]   r_err_cnt;
    logic [31:0]        r_bit_cnt;

    logic               w_pred;
    logic               w_mis;
    logic               w_hist_zero;
    logic [15:0]        w_win_err_sum;
    logic               w_err_hit;
    logic               w_bit_hit;

    assign w_pred        = r_hist[18] ^ r_hist[19] ^ r_hist[24] ^ r_hist[25];
    assign w_mis         = din ^ w_pred;
    assign w_hist_zero   = (r_hist == 26'd0);
    assign w_win_err_sum = r_win_err + {15'd0, w_mis};

    always_comb begin
        w_state_nx    = r_state;
        w_hist_nx     = r_hist;
        w_fill_nx     = r_fill;
        w_match_nx    = r_match;
        w_win_bits_nx = r_win_bits;
        w_win_err_nx  = r_win_err;
        w_err_hit     = 1'b0;
        w_bit_hit     = 1'b0;
        if (din_valid) begin
            case (r_state)
                ST_FILL: begin
                    w_hist_nx = {r_hist[24:0], din};
                    if (r_fill == 5'd25) begin
                        w_state_nx = ST_HUNT;
                        w_fill_nx  = 5'd0;
                        w_match_nx = 8'd0;
                    end else begin
                        w_fill_nx = r_fill + 5'd1;
                    end
                end
                ST_HUNT: begin
                    w_hist_nx = {r_hist[24:0], din};
                    // An all-zero history predicts zeros trivially, so it never earns credit.
                    if (!w_mis && !w_hist_zero) begin
                        if (r_match == c_LOCK_LAST) begin
                            w_state_nx    = ST_LOCKED;
                            w_match_nx    = 8'd0;
                            w_win_bits_nx = 16'd0;
                            w_win_err_nx  = 16'd0;
                        end else begin
                            w_match_nx = r_match + 8'd1;
                        end
                    end else begin
                        w_match_nx = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    w_bit_hit = 1'b1;
                    w_err_hit = w_mis;
                    w_hist_nx = {r_hist[24:0], w_pred};
                    // The threshold sees the current bit's error before any window rollover.
                    if (w_win_err_sum == c_LOSS_ERR) begin
                        w_state_nx    = ST_FILL;
                        w_hist_nx     = 26'd0;
                        w_fill_nx     = 5'd0;
                        w_win_bits_nx = 16'd0;
                        w_win_err_nx  = 16'd0;
                    end else if (r_win_bits == c_WIN_LAST) begin
                        w_win_bits_nx = 16'd0;
                        w_win_err_nx  = 16'd0;
                    end else begin
                        w_win_bits_nx = r_win_bits + 16'd1;
                        w_win_err_nx  = w_win_err_sum;
                    end
                end
                default: begin
                    w_state_nx = ST_FILL;
                    w_hist_nx  = 26'd0;
                    w_fill_nx  = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FILL;
            r_hist      <= 26'd0;
            r_fill      <= 5'd0;
            r_match     <= 8'd0;
            r_win_bits  <= 16'd0;
            r_win_err   <= 16'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
            r_bit_cnt   <= 32'd0;
        end else begin
            r_state     <= w_state_nx;
            r_hist      <= w_hist_nx;
            r_fill      <= w_fill_nx;
            r_match     <= w_match_nx;
            r_win_bits  <= w_win_bits_nx;
            r_win_err   <= w_win_err_nx;
            r_locked    <= (w_state_nx == ST_LOCKED);
            r_err_pulse <= w_err_hit;
            if (clr_cnt) begin
                r_err_cnt <= '0;
                r_bit_cnt <= 32'd0;
            end else begin
                if (w_err_hit && (r_err_cnt != {CNT_W{1'b1}}))
                    r_err_cnt <= r_err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                if (w_bit_hit && (r_bit_cnt != 32'hFFFF_FFFF))
                    r_bit_cnt <= r_bit_cnt + 32'd1;
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign bit_cnt   = r_bit_cnt;

endmodule
`default_nettype wire
